// File: rtl/alu_arb_pkg.sv
// Shared types and opcode constants for the ALU sharing arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'd0;
  localparam alu_op_t ALU_SUB = 3'd1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, searched cyclically.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic            found;
  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

  assign gnt_any = |req;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant.
// One operation in flight; result returned over a valid/ready channel tagged with the id.
// Optional: define ALU_ARB_STATS_EN to add the saturating stat_ops completion counter.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_y,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           stat_ops
`endif
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_next;
  logic [ID_W-1:0]   id_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              load, capture, rsp_fire;
  logic [DATA_W-1:0] sel_a, sel_b;
  alu_op_t           sel_op;

  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  alu_op_t           alu_op_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_zero_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  // Pointer moves just past the winner, wrapping at the last requester.
  always_comb begin
    rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          load      = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) rr_ptr_q <= rr_ptr_next;
    end
  end

  // Operand registers feed the ALU; result registers hold until the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      if (load) begin
        alu_a_q  <= sel_a;
        alu_b_q  <= sel_b;
        alu_op_q <= sel_op;
        id_q     <= gnt_idx;
      end
      if (capture) begin
        rsp_data_q <= alu_y;
        rsp_zero_q <= alu_zero;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_id   = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops_q;

  // Completed-response counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
    end else if (rsp_fire && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_q <= stat_ops_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU, transaction-level model, per-cycle compare,
// plus directed scenarios with hand-computed expectations.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(
    .NUM_REQ (N),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops  (stat_ops)
`endif
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // The shared ALU: purely combinational, fed only by the registered alu_* outputs.
  always_comb begin
    alu_y    = alu_fn(alu_a, alu_b, alu_op);
    alu_zero = (alu_y == 8'd0);
  end

  function automatic int pick(input logic [3:0] v, input int ptr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Transaction model: an accepted op is busy for two cycles, then offers its response
  // until it is taken. Operand outputs show the most recently accepted operands.
  logic       m_busy;
  int         m_age;
  int         m_ptr;
  int         m_id;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;
  int         m_ops;

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_ptr = 0; m_id = 0;
      m_a = 8'd0; m_b = 8'd0; m_op = 3'd0; m_ops = 0;
    end else if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = g;
        m_a    = 8'(req_a >> (g * 8));
        m_b    = 8'(req_b >> (g * 8));
        m_op   = 3'(req_op >> (g * 3));
        m_ptr  = (g + 1) % N;
      end
    end else if (m_age < 2) begin
      m_age = m_age + 1;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
      m_ops  = m_ops + 1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int         g;
    logic [3:0] exp_rdy;
    logic [7:0] exp_y;
    if (rst_n === 1'b1) begin
      exp_rdy = 4'd0;
      if (!m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) exp_rdy = 4'd1 << g;
      end
      check("cmp_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_busy && (m_age == 2)));
      check("cmp_alu_a", 32'(alu_a), 32'(m_a));
      check("cmp_alu_b", 32'(alu_b), 32'(m_b));
      check("cmp_alu_op", 32'(alu_op), 32'(m_op));
      if (m_busy && (m_age == 2)) begin
        exp_y = alu_fn(m_a, m_b, m_op);
        check("cmp_rsp_id", 32'(rsp_id), 32'(m_id));
        check("cmp_rsp_data", 32'(rsp_data), 32'(exp_y));
        check("cmp_rsp_zero", 32'(rsp_zero), 32'(exp_y == 8'd0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*3 +: 3] = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5];
    int last_cyc;
    logic got;
    exp_order = '{0, 1, 2, 3, 0};

    // 1: reset state, then idle with no requests
    rst_n = 1'b0; req_valid = 4'd0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
    end

    // 2: single op, 10+3 from requester 0
    step();
    set_req(0, 8'd10, 8'd3, ALU_ADD);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'd0;
    @(negedge clk);
    check("single_t1_valid", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    check("single_t2_valid", 32'(rsp_valid), 1);
    check("single_id", 32'(rsp_id), 0);
    check("single_data", 32'(rsp_data), 13);
    check("single_zero", 32'(rsp_zero), 0);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // 3: contention from a fresh pointer, all four valid
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(20 + i), 8'(i), ALU_ADD);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        if (req_ready != 4'd0) begin
          got = 1'b1;
          break;
        end
      end
      check("cont_grant_seen", 32'(got), 1);
      check("cont_grant", 32'(req_ready), 32'(4'd1 << exp_order[k]));
      if (k > 0) check("cont_spacing", 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
      step();
      req_a[exp_order[k]*8 +: 8] = req_a[exp_order[k]*8 +: 8] + 8'd16;
    end
    req_valid = 4'd0;
    repeat (4) step();

    // 4: backpressure, requester 1 then requester 3 waiting
    rsp_ready = 1'b0;
    set_req(1, 8'd200, 8'd100, ALU_SUB);
    set_req(3, 8'd1, 8'd2, ALU_ADD);
    req_valid = 4'b0010;
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_exec_ready", 32'(req_ready), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_data", 32'(rsp_data), 100);
      check("bp_id", 32'(rsp_id), 1);
      check("bp_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(rsp_valid), 1);
    check("bp_hs_ready", 32'(req_ready), 0);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // 5: zero result, 5-5 from requester 2
    set_req(2, 8'd5, 8'd5, ALU_SUB);
    req_valid = 4'b0100;
    @(negedge clk);
    check("zero_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'd0;
    step();
    @(negedge clk);
    check("zero_valid", 32'(rsp_valid), 1);
    check("zero_id", 32'(rsp_id), 2);
    check("zero_data", 32'(rsp_data), 0);
    check("zero_flag", 32'(rsp_zero), 1);
    repeat (3) step();

    // 6: reset during EXEC drops the op and restarts the pointer at 0
    set_req(2, 8'd7, 8'd9, ALU_ADD);
    req_valid = 4'b0100;
    @(negedge clk);
    check("mid_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'd0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp_valid), 0);
      check("mid_rsp_data", 32'(rsp_data), 0);
    end
    step();
    set_req(1, 8'd3, 8'd4, ALU_ADD);
    set_req(3, 8'd6, 8'd6, ALU_ADD);
    req_valid = 4'b1010;
    @(negedge clk);
    check("mid_after_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'd0;
    repeat (4) step();

`ifdef ALU_ARB_STATS_EN
    check("stat_ops", 32'(stat_ops), 32'(m_ops));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
